// File: rtl/bali_pkg.sv
// Shared fetch/control definitions: fetch FSM states, the halt opcode and
// the PC update helper used by the bytecode fetch stage.
package bali_pkg;

  typedef enum logic [2:0] {
    F_OP,
    F_A1,
    F_A2,
    F_LAST,
    VALID,
    HALT
  } fetch_state_t;

  // Opcode that stops fetch; control also treats it as "nothing to do".
  localparam logic [7:0] OP_HALT = 8'h00;

  // Adds a sign-extended 16-bit delta to a PC; callers truncate to their width.
  function automatic logic [31:0] pc_add(input logic [31:0] base,
                                         input logic [15:0] delta);
    return base + {{16{delta[15]}}, delta};
  endfunction

endpackage

// File: rtl/bytecode_fetch.sv
// Instruction fetch stage: reads opcode + two argument bytes from a
// synchronous-read byte memory and hands them to control until op_done.
module bytecode_fetch
  import bali_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] mem_addr,
  input  logic [7:0]      mem_rdata,
  output logic [7:0]      op_code,
  output logic [7:0]      arg1,
  output logic [7:0]      arg2,
  input  logic            op_done,
  input  logic [15:0]     offset,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [31:0]     instr_count
);

  fetch_state_t    state;
  logic [7:0]      op_reg;
  logic [7:0]      arg1_reg;
  logic [7:0]      arg2_reg;
  logic [PC_W-1:0] pc_next;

  assign pc_next = PC_W'(pc_add(32'(pc), offset));

  // Each memory byte arrives one cycle after its address, so the capture
  // state is always one step behind the state that drove the address.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state       <= F_OP;
      pc          <= RESET_PC;
      op_reg      <= '0;
      arg1_reg    <= '0;
      arg2_reg    <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        F_OP:   state <= F_A1;
        F_A1: begin
          op_reg <= mem_rdata;
          state  <= F_A2;
        end
        F_A2: begin
          arg1_reg <= mem_rdata;
          state    <= F_LAST;
        end
        F_LAST: begin
          arg2_reg <= mem_rdata;
          state    <= (op_reg == OP_HALT) ? HALT : VALID;
        end
        VALID: begin
          if (op_done) begin
            pc          <= pc_next;
            instr_count <= instr_count + 32'd1;
            state       <= F_OP;
          end
        end
        HALT:    state <= HALT;
        default: state <= F_OP;
      endcase
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    mem_addr = pc;
    case (state)
      F_A1:    mem_addr = pc + PC_W'(1);
      F_A2:    mem_addr = pc + PC_W'(2);
      default: mem_addr = pc;
    endcase
  end

  // Masked in the op_done cycle so control cannot re-launch a retired opcode.
  assign op_code = (state == VALID && !op_done) ? op_reg : OP_HALT;
  assign arg1    = arg1_reg;
  assign arg2    = arg2_reg;
  assign halted  = (state == HALT);

endmodule
